// File: rtl/sdram_ctrl_32mx32.sv
// Single-beat, closed-page SDRAM controller for a 32Mx32 array (two x16 parts).
// Runs power-up init and periodic auto-refresh, then serves one read or masked write at a time.
module sdram_ctrl_32mx32 #(
  parameter int T_INIT  = 10,
  parameter int T_RP    = 2,
  parameter int T_RCD   = 2,
  parameter int T_RFC   = 7,
  parameter int T_WR    = 2,
  parameter int T_MRD   = 2,
  parameter int CL      = 2,
  parameter int RD_SKEW = 1,
  parameter int T_REFI  = 780
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [26:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        sdram_cke,
  output logic        sdram_cs,
  output logic        sdram_ras,
  output logic        sdram_cas,
  output logic        sdram_we,
  output logic [12:0] sdram_a,
  output logic [1:0]  sdram_ba,
  output logic [3:0]  sdram_dqm,
  output logic [31:0] sdram_dq_o,
  output logic        sdram_dq_oe,
  input  logic [31:0] sdram_dq_i
);

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
    S_IDLE, S_REF, S_RCD, S_RD, S_WR
  } state_t;

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  localparam int TW = $clog2(T_REFI);

  localparam logic [7:0] C_INIT   = 8'(T_INIT - 1);
  localparam logic [7:0] C_RP     = 8'(T_RP - 1);
  localparam logic [7:0] C_RFC    = 8'(T_RFC - 1);
  localparam logic [7:0] C_MRD    = 8'(T_MRD - 1);
  localparam logic [7:0] C_RCD    = 8'(T_RCD - 1);
  localparam logic [7:0] C_RDCAP  = 8'(CL + RD_SKEW);
  localparam logic [7:0] C_WRDONE = 8'(T_WR + T_RP);
  localparam logic [TW-1:0] C_REFI = TW'(T_REFI - 1);

  // Mode register: burst length 1, sequential, CAS latency in a[6:4].
  localparam logic [12:0] MRS_VALUE = {6'b0, 3'(CL), 4'b0000};

  state_t        r_state;
  logic [7:0]    r_cnt;
  logic          r_refOn;
  logic [TW-1:0] r_refTimer;
  logic          r_refPending;
  logic          r_write;
  logic [1:0]    r_bank;
  logic [9:0]    r_col;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;

  logic w_refTick;
  logic w_issueRef;
  logic w_pendNext;
  logic w_unused;

  assign w_refTick  = r_refOn && (r_refTimer == C_REFI);
  assign w_issueRef = (r_state == S_IDLE) && r_refPending;
  assign w_pendNext = w_refTick || (r_refPending && !w_issueRef);
  assign w_unused   = ^req_addr[1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_INIT_WAIT;
      r_cnt        <= '0;
      r_refOn      <= 1'b0;
      r_refTimer   <= '0;
      r_refPending <= 1'b0;
      r_write      <= 1'b0;
      r_bank       <= '0;
      r_col        <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      req_ready    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      sdram_cke    <= 1'b0;
      {sdram_cs, sdram_ras, sdram_cas, sdram_we} <= 4'b1111;
      sdram_a      <= '0;
      sdram_ba     <= '0;
      sdram_dqm    <= 4'hF;
      sdram_dq_o   <= '0;
      sdram_dq_oe  <= 1'b0;
    end else begin
      // Every cycle is a NOP with all bytes masked unless a branch below says otherwise.
      sdram_cke    <= 1'b1;
      {sdram_cs, sdram_ras, sdram_cas, sdram_we} <= CMD_NOP;
      sdram_a      <= '0;
      sdram_ba     <= '0;
      sdram_dqm    <= 4'hF;
      sdram_dq_oe  <= 1'b0;
      req_ready    <= 1'b0;
      resp_valid   <= 1'b0;
      r_cnt        <= r_cnt + 1'b1;
      r_refPending <= w_pendNext;
      if (r_refOn) r_refTimer <= w_refTick ? '0 : r_refTimer + 1'b1;

      case (r_state)
        S_INIT_WAIT: if (r_cnt == C_INIT) begin
          {sdram_cs, sdram_ras, sdram_cas, sdram_we} <= CMD_PRE;
          sdram_a <= 13'h0400;
          r_state <= S_INIT_PRE;
          r_cnt   <= '0;
        end
        S_INIT_PRE: if (r_cnt == C_RP) begin
          {sdram_cs, sdram_ras, sdram_cas, sdram_we} <= CMD_REF;
          r_state <= S_INIT_REF1;
          r_cnt   <= '0;
        end
        S_INIT_REF1: if (r_cnt == C_RFC) begin
          {sdram_cs, sdram_ras, sdram_cas, sdram_we} <= CMD_REF;
          r_state <= S_INIT_REF2;
          r_cnt   <= '0;
        end
        S_INIT_REF2: if (r_cnt == C_RFC) begin
          {sdram_cs, sdram_ras, sdram_cas, sdram_we} <= CMD_MRS;
          sdram_a <= MRS_VALUE;
          r_state <= S_INIT_MRS;
          r_cnt   <= '0;
        end
        S_INIT_MRS: if (r_cnt == C_MRD) begin
          r_state    <= S_IDLE;
          req_ready  <= 1'b1;
          r_refOn    <= 1'b1;
          r_refTimer <= '0;
        end
        S_IDLE: begin
          if (r_refPending) begin
            {sdram_cs, sdram_ras, sdram_cas, sdram_we} <= CMD_REF;
            r_state <= S_REF;
            r_cnt   <= '0;
          end else if (req_valid && req_ready) begin
            {sdram_cs, sdram_ras, sdram_cas, sdram_we} <= CMD_ACT;
            sdram_a  <= req_addr[26:14];
            sdram_ba <= req_addr[13:12];
            r_bank   <= req_addr[13:12];
            r_col    <= req_addr[11:2];
            r_write  <= req_write;
            r_wdata  <= req_wdata;
            r_wstrb  <= req_wstrb;
            r_state  <= S_RCD;
            r_cnt    <= '0;
          end else begin
            req_ready <= !w_pendNext;
          end
        end
        S_REF: if (r_cnt == C_RFC) begin
          r_state   <= S_IDLE;
          req_ready <= !w_pendNext;
        end
        // Column command always carries a[10]=1 so the bank closes on its own.
        S_RCD: if (r_cnt == C_RCD) begin
          sdram_a  <= {2'b00, 1'b1, r_col};
          sdram_ba <= r_bank;
          r_cnt    <= '0;
          if (r_write) begin
            {sdram_cs, sdram_ras, sdram_cas, sdram_we} <= CMD_WRITE;
            sdram_dq_oe <= 1'b1;
            sdram_dq_o  <= r_wdata;
            sdram_dqm   <= ~r_wstrb;
            r_state     <= S_WR;
          end else begin
            {sdram_cs, sdram_ras, sdram_cas, sdram_we} <= CMD_READ;
            sdram_dqm <= 4'h0;
            r_state   <= S_RD;
          end
        end
        S_RD: if (r_cnt == C_RDCAP) begin
          resp_rdata <= sdram_dq_i;
          resp_valid <= 1'b1;
          r_state    <= S_IDLE;
          req_ready  <= !w_pendNext;
        end
        S_WR: if (r_cnt == C_WRDONE) begin
          resp_valid <= 1'b1;
          r_state    <= S_IDLE;
          req_ready  <= !w_pendNext;
        end
        default: begin
          r_state <= S_INIT_WAIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_ctrl_32mx32.sv
// Directed bench for sdram_ctrl_32mx32: init timing, masked writes, reads, refresh
// arbitration and mid-access reset, against a small behavioural SDRAM model.
module tb_sdram_ctrl_32mx32;

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam int         RD_DELAY  = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [26:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        sdram_cke;
  logic        sdram_cs;
  logic        sdram_ras;
  logic        sdram_cas;
  logic        sdram_we;
  logic [12:0] sdram_a;
  logic [1:0]  sdram_ba;
  logic [3:0]  sdram_dqm;
  logic [31:0] sdram_dq_o;
  logic        sdram_dq_oe;
  logic [31:0] sdram_dq_i;
  logic [3:0]  cmd;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int base   = 0;

  assign cmd = {sdram_cs, sdram_ras, sdram_cas, sdram_we};

  sdram_ctrl_32mx32 dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wstrb   (req_wstrb),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .sdram_cke   (sdram_cke),
    .sdram_cs    (sdram_cs),
    .sdram_ras   (sdram_ras),
    .sdram_cas   (sdram_cas),
    .sdram_we    (sdram_we),
    .sdram_a     (sdram_a),
    .sdram_ba    (sdram_ba),
    .sdram_dqm   (sdram_dqm),
    .sdram_dq_o  (sdram_dq_o),
    .sdram_dq_oe (sdram_dq_oe),
    .sdram_dq_i  (sdram_dq_i)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural SDRAM: tracks the open row per bank, applies byte masks on WRITE,
  // and presents read data only in the cycle CL+RD_SKEW after READ (board skew included).
  logic [31:0] mem [0:255];
  logic [12:0] actRow [0:3];
  logic [31:0] rdData = 32'h0;
  int          rdCnt  = 0;

  function automatic logic [7:0] memKey(input logic [1:0] ba, input logic [12:0] row,
                                        input logic [9:0] col);
    return {ba, row[0], col[4:0]};
  endfunction

  function automatic logic [31:0] mergeWord(input logic [31:0] oldW, input logic [31:0] newW,
                                            input logic [3:0] mask);
    logic [31:0] w;
    w = oldW;
    for (int b = 0; b < 4; b++) if (!mask[b]) w[b*8 +: 8] = newW[b*8 +: 8];
    return w;
  endfunction

  always @(posedge clock) begin
    if (rdCnt == 1) begin
      sdram_dq_i <= rdData;
      rdCnt      <= 0;
    end else begin
      sdram_dq_i <= 32'h5A5A5A5A;
      if (rdCnt > 1) rdCnt <= rdCnt - 1;
    end
    if (sdram_cke && cmd == CMD_ACT) actRow[sdram_ba] <= sdram_a;
    if (sdram_cke && cmd == CMD_WRITE)
      mem[memKey(sdram_ba, actRow[sdram_ba], sdram_a[9:0])] <=
        mergeWord(mem[memKey(sdram_ba, actRow[sdram_ba], sdram_a[9:0])], sdram_dq_o, sdram_dqm);
    if (sdram_cke && cmd == CMD_READ) begin
      rdData <= mem[memKey(sdram_ba, actRow[sdram_ba], sdram_a[9:0])];
      rdCnt  <= RD_DELAY - 1;
    end
  end

  // Drive one request onto the SoC port.
  task automatic applyStimulus(input logic valid, input logic write, input logic [26:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb);
    req_valid = valid;
    req_write = write;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h (cycle %0d)", tag, obs, exp, cyc - base);
    end
  endtask

  // Advance to the negedge inside relative cycle n.
  task automatic waitUntil(input int n);
    while (cyc - base < n) @(negedge clock);
  endtask

  // Check the full init command sequence from the reset-release cycle.
  task automatic checkInit(input string pfx);
    waitUntil(1);
    checkOutput({pfx, "_cke1"}, 32'(sdram_cke), 32'h1);
    checkOutput({pfx, "_nop1"}, 32'(cmd), 32'(CMD_NOP));
    waitUntil(9);
    checkOutput({pfx, "_nop9"}, 32'(cmd), 32'(CMD_NOP));
    waitUntil(10);
    checkOutput({pfx, "_pre"}, 32'(cmd), 32'(CMD_PRE));
    checkOutput({pfx, "_preA10"}, 32'(sdram_a[10]), 32'h1);
    waitUntil(11);
    checkOutput({pfx, "_nop11"}, 32'(cmd), 32'(CMD_NOP));
    waitUntil(12);
    checkOutput({pfx, "_ref1"}, 32'(cmd), 32'(CMD_REF));
    waitUntil(19);
    checkOutput({pfx, "_ref2"}, 32'(cmd), 32'(CMD_REF));
    waitUntil(26);
    checkOutput({pfx, "_mrs"}, 32'(cmd), 32'(CMD_MRS));
    checkOutput({pfx, "_mrsA"}, 32'(sdram_a), 32'h020);
    checkOutput({pfx, "_mrsBa"}, 32'(sdram_ba), 32'h0);
    waitUntil(27);
    checkOutput({pfx, "_ready27"}, 32'(req_ready), 32'h0);
    waitUntil(28);
    checkOutput({pfx, "_ready28"}, 32'(req_ready), 32'h1);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 27'h0, 32'h0, 4'h0);
    repeat (3) @(negedge clock);
    checkOutput("rst_cke", 32'(sdram_cke), 32'h0);
    checkOutput("rst_cmd", 32'(cmd), 32'hF);
    checkOutput("rst_dqm", 32'(sdram_dqm), 32'hF);
    checkOutput("rst_oe", 32'(sdram_dq_oe), 32'h0);
    checkOutput("rst_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_resp", 32'(resp_valid), 32'h0);
    checkOutput("rst_a", 32'(sdram_a), 32'h0);
    reset = 1'b0;
    base  = cyc;
    checkInit("init");

    // Full write of 0xDEADBEEF to 0x100: row 0, bank 0, col 0x040.
    applyStimulus(1'b1, 1'b1, 27'h0000100, 32'hDEADBEEF, 4'hF);
    waitUntil(29);
    checkOutput("w1_act", 32'(cmd), 32'(CMD_ACT));
    checkOutput("w1_row", 32'(sdram_a), 32'h0);
    checkOutput("w1_bank", 32'(sdram_ba), 32'h0);
    applyStimulus(1'b0, 1'b0, 27'h0, 32'h0, 4'h0);
    waitUntil(31);
    checkOutput("w1_wr", 32'(cmd), 32'(CMD_WRITE));
    checkOutput("w1_col", 32'(sdram_a), 32'h440);
    checkOutput("w1_oe", 32'(sdram_dq_oe), 32'h1);
    checkOutput("w1_dq", sdram_dq_o, 32'hDEADBEEF);
    checkOutput("w1_dqm", 32'(sdram_dqm), 32'h0);
    waitUntil(32);
    checkOutput("w1_oeOff", 32'(sdram_dq_oe), 32'h0);
    checkOutput("w1_dqmOff", 32'(sdram_dqm), 32'hF);
    waitUntil(35);
    checkOutput("w1_respEarly", 32'(resp_valid), 32'h0);
    waitUntil(36);
    checkOutput("w1_resp", 32'(resp_valid), 32'h1);
    checkOutput("w1_ready", 32'(req_ready), 32'h1);

    // Read it back: resp 6 cycles after ACT (37 -> 43).
    applyStimulus(1'b1, 1'b0, 27'h0000100, 32'h0, 4'h0);
    waitUntil(37);
    checkOutput("r1_act", 32'(cmd), 32'(CMD_ACT));
    applyStimulus(1'b0, 1'b0, 27'h0, 32'h0, 4'h0);
    waitUntil(39);
    checkOutput("r1_rd", 32'(cmd), 32'(CMD_READ));
    checkOutput("r1_col", 32'(sdram_a), 32'h440);
    checkOutput("r1_dqm", 32'(sdram_dqm), 32'h0);
    waitUntil(42);
    checkOutput("r1_respEarly", 32'(resp_valid), 32'h0);
    waitUntil(43);
    checkOutput("r1_resp", 32'(resp_valid), 32'h1);
    checkOutput("r1_data", resp_rdata, 32'hDEADBEEF);

    // Fill top word with 0xAABBCCDD, then partial write 0x11223344 with wstrb=0101.
    applyStimulus(1'b1, 1'b1, 27'h7FFFFFC, 32'hAABBCCDD, 4'hF);
    waitUntil(44);
    applyStimulus(1'b0, 1'b0, 27'h0, 32'h0, 4'h0);
    waitUntil(51);
    checkOutput("w2_resp", 32'(resp_valid), 32'h1);
    applyStimulus(1'b1, 1'b1, 27'h7FFFFFC, 32'h11223344, 4'b0101);
    waitUntil(52);
    checkOutput("w3_act", 32'(cmd), 32'(CMD_ACT));
    checkOutput("w3_row", 32'(sdram_a), 32'h1FFF);
    checkOutput("w3_bank", 32'(sdram_ba), 32'h3);
    applyStimulus(1'b0, 1'b0, 27'h0, 32'h0, 4'h0);
    waitUntil(54);
    checkOutput("w3_wr", 32'(cmd), 32'(CMD_WRITE));
    checkOutput("w3_col", 32'(sdram_a), 32'h7FF);
    checkOutput("w3_dqm", 32'(sdram_dqm), 32'hA);
    checkOutput("w3_dq", sdram_dq_o, 32'h11223344);
    waitUntil(59);
    checkOutput("w3_resp", 32'(resp_valid), 32'h1);
    applyStimulus(1'b1, 1'b0, 27'h7FFFFFC, 32'h0, 4'h0);
    waitUntil(60);
    applyStimulus(1'b0, 1'b0, 27'h0, 32'h0, 4'h0);
    waitUntil(66);
    checkOutput("r2_resp", 32'(resp_valid), 32'h1);
    checkOutput("r2_data", resp_rdata, 32'hAA22CC44);

    // wstrb=0: full command sequence with every byte masked, memory unchanged.
    applyStimulus(1'b1, 1'b1, 27'h0000100, 32'h12345678, 4'h0);
    waitUntil(67);
    checkOutput("w4_act", 32'(cmd), 32'(CMD_ACT));
    applyStimulus(1'b0, 1'b0, 27'h0, 32'h0, 4'h0);
    waitUntil(69);
    checkOutput("w4_wr", 32'(cmd), 32'(CMD_WRITE));
    checkOutput("w4_dqm", 32'(sdram_dqm), 32'hF);
    checkOutput("w4_oe", 32'(sdram_dq_oe), 32'h1);
    waitUntil(74);
    checkOutput("w4_resp", 32'(resp_valid), 32'h1);

    // Back-to-back reads in bank 0 then bank 3, second request held valid.
    applyStimulus(1'b1, 1'b0, 27'h0000100, 32'h0, 4'h0);
    waitUntil(75);
    checkOutput("b2b_act1", 32'(cmd), 32'(CMD_ACT));
    applyStimulus(1'b1, 1'b0, 27'h7FFFFFC, 32'h0, 4'h0);
    waitUntil(80);
    checkOutput("b2b_wait", 32'(cmd), 32'(CMD_NOP));
    checkOutput("b2b_readyLow", 32'(req_ready), 32'h0);
    waitUntil(81);
    checkOutput("b2b_resp1", 32'(resp_valid), 32'h1);
    checkOutput("b2b_data1", resp_rdata, 32'hDEADBEEF);
    checkOutput("b2b_noAct", 32'(cmd), 32'(CMD_NOP));
    waitUntil(82);
    checkOutput("b2b_act2", 32'(cmd), 32'(CMD_ACT));
    checkOutput("b2b_bank2", 32'(sdram_ba), 32'h3);
    applyStimulus(1'b0, 1'b0, 27'h0, 32'h0, 4'h0);
    waitUntil(87);
    checkOutput("b2b_hold", resp_rdata, 32'hDEADBEEF);
    waitUntil(88);
    checkOutput("b2b_resp2", 32'(resp_valid), 32'h1);
    checkOutput("b2b_data2", resp_rdata, 32'hAA22CC44);

    // Refresh timer started at cycle 28, so ref_pending shows from cycle 808.
    waitUntil(807);
    checkOutput("ref_readyBefore", 32'(req_ready), 32'h1);
    waitUntil(808);
    checkOutput("ref_readyDrop", 32'(req_ready), 32'h0);
    applyStimulus(1'b1, 1'b0, 27'h0000100, 32'h0, 4'h0);
    waitUntil(809);
    checkOutput("ref_cmd", 32'(cmd), 32'(CMD_REF));
    checkOutput("ref_readyAtRef", 32'(req_ready), 32'h0);
    for (int c = 810; c <= 815; c++) begin
      waitUntil(c);
      checkOutput("ref_readyLow", 32'(req_ready), 32'h0);
      checkOutput("ref_nop", 32'(cmd), 32'(CMD_NOP));
    end
    waitUntil(816);
    checkOutput("ref_readyBack", 32'(req_ready), 32'h1);
    waitUntil(817);
    checkOutput("ref_act", 32'(cmd), 32'(CMD_ACT));
    applyStimulus(1'b0, 1'b0, 27'h0, 32'h0, 4'h0);
    waitUntil(823);
    checkOutput("ref_resp", 32'(resp_valid), 32'h1);
    checkOutput("ref_data", resp_rdata, 32'hDEADBEEF);

    // Reset between READ (826) and data capture (end of 829).
    applyStimulus(1'b1, 1'b0, 27'h7FFFFFC, 32'h0, 4'h0);
    waitUntil(824);
    applyStimulus(1'b0, 1'b0, 27'h0, 32'h0, 4'h0);
    waitUntil(826);
    checkOutput("mid_rd", 32'(cmd), 32'(CMD_READ));
    waitUntil(827);
    reset = 1'b1;
    waitUntil(828);
    checkOutput("mid_cmd", 32'(cmd), 32'hF);
    checkOutput("mid_dqm", 32'(sdram_dqm), 32'hF);
    checkOutput("mid_cke", 32'(sdram_cke), 32'h0);
    checkOutput("mid_resp", 32'(resp_valid), 32'h0);
    reset = 1'b0;
    base  = cyc;
    for (int c = 1; c <= 5; c++) begin
      waitUntil(c);
      checkOutput("mid_noResp", 32'(resp_valid), 32'h0);
    end
    checkInit("reinit");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_ctrl_32mx32.md
Name: sdram_ctrl_32mx32

Overview:
Single-beat SDRAM controller that drives the pins of the 32Mx32 SDRAM array (two x16 devices sharing command/address, 32-bit dq, 4-bit dqm).
Sits between the SoC-side memory request port and the SDRAM pins.
Performs the power-up init sequence and periodic auto-refresh.
Serves one 32-bit read or byte-masked write at a time, closed-page, using auto-precharge.

Parameters:
T_INIT, 10, NOP cycles after reset before the init PRECHARGE (sim value)
T_RP, 2, PRECHARGE-to-command cycles
T_RCD, 2, ACTIVE-to-READ/WRITE cycles
T_RFC, 7, REFRESH-to-command cycles
T_WR, 2, write recovery cycles before the auto-precharge completes
T_MRD, 2, MRS-to-command cycles
CL, 2, CAS latency; the MRS value encodes it
RD_SKEW, 1, extra capture cycles after CL; constraint CL+RD_SKEW >= T_RP
T_REFI, 780, cycles between refresh requests

Ports:
clock input 1 system clock; SDRAM clk is the same clock
reset input 1 synchronous, active-high
req_valid input 1 request present
req_ready output 1 controller accepts request this cycle
req_write input 1 1=write, 0=read
req_addr input 27 byte address; [1:0] ignored
req_wdata input 32 write data
req_wstrb input 4 byte enables
resp_valid output 1 one-cycle completion pulse (read and write)
resp_rdata output 32 read data, valid with resp_valid on reads
sdram_cke output 1 clock enable
sdram_cs output 1 chip select, active-low
sdram_ras output 1 row strobe, active-low
sdram_cas output 1 column strobe, active-low
sdram_we output 1 write enable, active-low
sdram_a output 13 address
sdram_ba output 2 bank
sdram_dqm output 4 byte masks, active-high mask
sdram_dq_o output 32 write data
sdram_dq_oe output 1 dq tristate enable; the top level builds the inout
sdram_dq_i input 32 dq read value

Behaviour:
- Reset values, all registered: cke=0, cs=ras=cas=we=1, a=0, ba=0, dqm=4'hF, dq_o=0, dq_oe=0, req_ready=0, resp_valid=0, resp_rdata=0. Reset asserted in any state, including mid-access, returns the block to INIT_WAIT. An in-flight access is dropped with no resp_valid.
- Commands {cs,ras,cas,we}: NOP 0111, ACT 0011, READ 0101, WRITE 0100, PRE 0010, REF 0001, MRS 0000. Every non-command cycle drives NOP.
- Address map: col=addr[11:2] on a[9:0] with a[10]=1 (auto-precharge) and a[12:11]=0. bank=addr[13:12]. row=addr[26:14].
- Init sequence (cke=1 from the first cycle after reset):
  - INIT_WAIT: T_INIT NOPs.
  - INIT_PRE: PRE with a[10]=1 (all banks), then T_RP-1 NOPs.
  - INIT_REF1 and INIT_REF2: each is REF followed by T_RFC-1 NOPs.
  - INIT_MRS: MRS with ba=0, a=13'h020 (BL=1, sequential, CL=2), then T_MRD-1 NOPs.
  - Then IDLE.
- Refresh timer: starts at 0 on IDLE entry after init, counts every cycle, and sets ref_pending at T_REFI-1 then wraps to 0. ref_pending clears when REF is issued.
- req_ready=1 only in IDLE with ref_pending=0. A request is accepted on an edge where req_valid&&req_ready. Refresh beats a request present in the same cycle.
- REF state (from IDLE when ref_pending): REF command, then T_RFC-1 NOPs, then back to IDLE. An access is never interrupted by refresh.
- Read, with ACT on cycle C:
  - ACT on C with the row; READ on C+T_RCD with dqm=0.
  - sdram_dq_i captured at the end of cycle C+T_RCD+CL+RD_SKEW.
  - resp_valid=1 and resp_rdata updated on the next cycle, which is the first IDLE cycle (C+6 with defaults).
- Write, with ACT on cycle C:
  - WRITE on C+T_RCD with dq_oe=1, dq_o=wdata and dqm=~wstrb, for that cycle only.
  - Then T_WR+T_RP NOPs. resp_valid is asserted in the following cycle, which is the first IDLE cycle.
- Request fields are latched on accept and req_* are ignored until IDLE. dqm=4'hF outside READ/WRITE. resp_rdata holds its value between reads.
- wstrb=0 still performs the full command sequence, with all bytes masked.

Test Plan:
- Init: release reset → cke=1 at cycle 1, PRE(a[10]=1) at cycle 10, REF at 12 and 19, MRS a=0x020 at 26, req_ready=1 from cycle 28.
- Write 0xDEADBEEF, wstrb=F, to 0x0000100, then read it → ACT row 0 bank 0, WRITE col 0x040, then READ returns 0xDEADBEEF with resp_valid 6 cycles after ACT.
- Write wstrb=4'b0101 data 0x11223344 over 0xAABBCCDD at 0x7FFFFFC → WRITE dqm=4'b1010, row 0x1FFF, bank 3, col 0x3FF; readback 0xAA22CC44.
- Hold req_valid across the T_REFI boundary → REF issued first, req_ready=0 for T_RFC cycles, then the request is served.
- Assert reset between READ and data capture → no resp_valid, pins go NOP with dqm=F, full init sequence repeats.
- Back-to-back reads of two banks → second ACT no earlier than the cycle after the first resp_valid; data correct for both.
